// File: rtl/rr_arb_mux_pkg.sv
// Shared helpers for the round-robin arbiter slice: FSM state codes and the
// lowest-set-bit idiom that several muxes in this codebase reuse.
package rr_arb_mux_pkg;

    // Widest one-hot vector lsb_isolate handles; callers zero-extend into it
    localparam int LSB_MAX_W = 64;

    // Arbiter FSM states
    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_LOCK = 1'b1;

    // Keep only the lowest set bit of x (zero stays zero)
    function automatic logic [LSB_MAX_W-1:0] lsb_isolate(input logic [LSB_MAX_W-1:0] x);
        return x & ~(x - {{(LSB_MAX_W-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/one_hot_mux.sv
// Generic AND-OR data mux driven by a one-hot (or all-zero) select vector.
// An all-zero select yields all-zero data.
module one_hot_mux #(
    parameter int WIDTH         = 32,
    parameter int CNT           = 5,
    parameter int ONE_HOT_CHECK = 1
) (
    input  logic [CNT-1:0]       sel_i,
    input  logic [WIDTH*CNT-1:0] data_i,
    output logic [WIDTH-1:0]     data_o
);

    // OR together every lane whose select bit is set
    always_comb begin
        data_o = '0;
        for (int i = 0; i < CNT; i++) begin
            if (sel_i[i]) begin
                data_o = data_o | data_i[WIDTH*i +: WIDTH];
            end
        end
    end

    generate
        if (ONE_HOT_CHECK != 0) begin : gCheck
            // Flag selects with more than one bit set during simulation
            always_comb begin
                assert ($onehot0(sel_i));
            end
        end
    endgenerate

endmodule

// File: rtl/rr_pick.sv
// Masked-priority round-robin pick: the lowest valid requester strictly above
// the pointer wins, falling back to the lowest valid requester overall.
module rr_pick
    import rr_arb_mux_pkg::*;
#(
    parameter int CNT = 5
) (
    input  logic [CNT-1:0] req_vld,
    input  logic [CNT-1:0] ptr,
    output logic [CNT-1:0] pick
);

    logic [CNT-1:0] atOrBelow;
    logic [CNT-1:0] hi;

    // When ptr is the top bit the shift overflows to zero, the mask becomes
    // all ones, hi is empty and the pick wraps back to index 0.
    assign atOrBelow = (ptr << 1) - CNT'(1);
    assign hi        = req_vld & ~atOrBelow;

    // Prefer requesters above the pointer, else wrap to the full valid set
    always_comb begin
        if (|hi) begin
            pick = CNT'(lsb_isolate(LSB_MAX_W'(hi)));
        end else begin
            pick = CNT'(lsb_isolate(LSB_MAX_W'(req_vld)));
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// Round-robin arbiter with packet locking in front of one registered output
// channel. A multi-beat packet keeps the grant until its last beat is taken.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CNT-1:0]       req_vld,
    input  logic [CNT-1:0]       req_last,
    input  logic [WIDTH*CNT-1:0] req_data,
    output logic [CNT-1:0]       req_rdy,
    output logic                 out_vld,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic [CNT-1:0]       out_src,
    input  logic                 out_rdy
);

    // Pointer resets to the top requester so requester 0 wins first
    localparam logic [CNT-1:0] PTR_RST = {1'b1, {(CNT-1){1'b0}}};

    logic [0:0]       state_q,    state_d;
    logic [CNT-1:0]   lock_q,     lock_d;
    logic [CNT-1:0]   ptr_q,      ptr_d;
    logic             out_vld_q,  out_vld_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [CNT-1:0]   out_src_q,  out_src_d;

    logic [CNT-1:0]   pick;
    logic [CNT-1:0]   grant;
    logic [WIDTH-1:0] muxData;
    logic             load;
    logic             winLast;
    logic             accept;

    rr_pick #(
        .CNT(CNT)
    ) uPick (
        .req_vld(req_vld),
        .ptr    (ptr_q),
        .pick   (pick)
    );

    one_hot_mux #(
        .WIDTH        (WIDTH),
        .CNT          (CNT),
        .ONE_HOT_CHECK(0)
    ) uMux (
        .sel_i (grant),
        .data_i(req_data),
        .data_o(muxData)
    );

    assign load    = !out_vld_q || out_rdy;
    assign winLast = |(grant & req_last);
    assign accept  = load && (|grant);
    assign req_rdy = grant & {CNT{load}};

    // Grant follows the rotating pick when idle, or only the locked owner
    always_comb begin
        if (state_q == STATE_IDLE) begin
            grant = pick;
        end else begin
            grant = lock_q & req_vld;
        end
    end

    // Lock on a non-last beat, release and advance the pointer on the last
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        ptr_d   = ptr_q;
        if (accept) begin
            if (state_q == STATE_IDLE) begin
                if (winLast) begin
                    ptr_d = grant;
                end else begin
                    lock_d  = grant;
                    state_d = STATE_LOCK;
                end
            end else if (winLast) begin
                ptr_d   = lock_q;
                lock_d  = '0;
                state_d = STATE_IDLE;
            end
        end
    end

    // Output stage loads the winner, or empties when nobody is granted
    always_comb begin
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        out_src_d  = out_src_q;
        if (load) begin
            if (|grant) begin
                out_vld_d  = 1'b1;
                out_data_d = muxData;
                out_last_d = winLast;
                out_src_d  = grant;
            end else begin
                out_vld_d  = 1'b0;
            end
        end
    end

    // State registers; reset abandons any partially sent packet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= STATE_IDLE;
            lock_q     <= '0;
            ptr_q      <= PTR_RST;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            out_src_q  <= '0;
        end else begin
            state_q    <= state_d;
            lock_q     <= lock_d;
            ptr_q      <= ptr_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            out_src_q  <= out_src_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign out_last = out_last_q;
    assign out_src  = out_src_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: directed scenarios plus a randomized
// run, all checked against a behavioural arbitration model.
module tb_rr_arb_mux;

    localparam int WIDTH = 32;
    localparam int CNT   = 5;

    logic                 clk;
    logic                 rst;
    logic [CNT-1:0]       req_vld;
    logic [CNT-1:0]       req_last;
    logic [WIDTH*CNT-1:0] req_data;
    logic [CNT-1:0]       req_rdy;
    logic                 out_vld;
    logic [WIDTH-1:0]     out_data;
    logic                 out_last;
    logic [CNT-1:0]       out_src;
    logic                 out_rdy;

    int testsRun;
    int testsFailed;

    // Behavioural model: integer pointer/lock indices and the output stage
    int               mPtr;
    int               mLock;
    logic             mOutVld;
    logic [WIDTH-1:0] mOutData;
    logic             mOutLast;
    logic [CNT-1:0]   mOutSrc;

    logic [WIDTH-1:0] pendData [CNT];
    int               lastGrant;

    rr_arb_mux #(
        .WIDTH(WIDTH),
        .CNT  (CNT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_vld (req_vld),
        .req_last(req_last),
        .req_data(req_data),
        .req_rdy (req_rdy),
        .out_vld (out_vld),
        .out_data(out_data),
        .out_last(out_last),
        .out_src (out_src),
        .out_rdy (out_rdy)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if it does not match
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mPtr     = CNT - 1;
        mLock    = -1;
        mOutVld  = 1'b0;
        mOutData = '0;
        mOutLast = 1'b0;
        mOutSrc  = '0;
    endtask

    // Who the rules say wins this cycle: the lock owner if valid, otherwise
    // the first valid requester after the pointer, wrapping around to 0
    function automatic int modelPick(input logic [CNT-1:0] vld);
        if (mLock >= 0) begin
            return vld[mLock] ? mLock : -1;
        end
        for (int i = mPtr + 1; i < CNT; i++) begin
            if (vld[i]) return i;
        end
        for (int i = 0; i < CNT; i++) begin
            if (vld[i]) return i;
        end
        return -1;
    endfunction

    task automatic checkAll(input string tag);
        checkOutput({tag, ".out_vld"}, 64'(out_vld), 64'(mOutVld));
        checkOutput({tag, ".out_src"}, 64'(out_src), 64'(mOutSrc));
        checkOutput({tag, ".out_last"}, 64'(out_last), 64'(mOutLast));
        checkOutput({tag, ".out_data"}, 64'(out_data), 64'(mOutData));
    endtask

    // One clock cycle: drive inputs at the falling edge, check ready before
    // the rising edge, advance the model, then check outputs at the next fall
    task automatic applyStimulus(input logic [CNT-1:0] vld, input logic [CNT-1:0] last,
                                 input logic rdy);
        int               g;
        logic             load;
        logic [CNT-1:0]   expRdy;
        req_vld  = vld;
        req_last = last;
        out_rdy  = rdy;
        for (int i = 0; i < CNT; i++) begin
            req_data[WIDTH*i +: WIDTH] = pendData[i];
        end
        #1;
        load   = !mOutVld || rdy;
        g      = modelPick(vld);
        expRdy = '0;
        if (load && g >= 0) expRdy[g] = 1'b1;
        checkOutput("req_rdy", 64'(req_rdy), 64'(expRdy));
        @(posedge clk);
        lastGrant = (load && g >= 0) ? g : -1;
        if (load) begin
            if (g >= 0) begin
                mOutVld  = 1'b1;
                mOutData = pendData[g];
                mOutLast = last[g];
                mOutSrc  = '0;
                mOutSrc[g] = 1'b1;
                if (last[g]) begin
                    mPtr  = g;
                    mLock = -1;
                end else begin
                    mLock = g;
                end
                pendData[g] = $urandom;
            end else begin
                mOutVld = 1'b0;
            end
        end
        @(negedge clk);
        checkAll("cycle");
    endtask

    initial begin
        logic [CNT-1:0] expSrc [6];
        logic [CNT-1:0] rVld;
        logic [CNT-1:0] rLast;
        logic [WIDTH-1:0] heldData;
        bit             pend [CNT];
        bit             pLast [CNT];

        testsRun    = 0;
        testsFailed = 0;
        lastGrant   = -1;
        for (int i = 0; i < CNT; i++) pendData[i] = $urandom;
        rst      = 1'b1;
        req_vld  = '0;
        req_last = '0;
        req_data = '0;
        out_rdy  = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        checkAll("reset");
        checkOutput("reset.req_rdy", 64'(req_rdy), 64'd0);
        rst = 1'b0;

        // Rotating priority over 1,2,4 with single-beat transfers
        expSrc[0] = 5'b00010; expSrc[1] = 5'b00100; expSrc[2] = 5'b10000;
        expSrc[3] = 5'b00010; expSrc[4] = 5'b00100; expSrc[5] = 5'b10000;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(5'b10110, 5'b11111, 1'b1);
            checkOutput("rr.src", 64'(out_src), 64'(expSrc[k]));
            checkOutput("rr.vld", 64'(out_vld), 64'd1);
        end

        // Wrap from requester 4 back to 0
        applyStimulus(5'b10001, 5'b11111, 1'b1);
        checkOutput("wrap.src0", 64'(out_src), 64'(5'b00001));
        applyStimulus(5'b10001, 5'b11111, 1'b1);
        checkOutput("wrap.src4", 64'(out_src), 64'(5'b10000));

        // Requester 2 locks for three beats while 3 waits
        applyStimulus(5'b01100, 5'b11011, 1'b1);
        checkOutput("lock.src1", 64'(out_src), 64'(5'b00100));
        applyStimulus(5'b01100, 5'b11011, 1'b1);
        checkOutput("lock.src2", 64'(out_src), 64'(5'b00100));
        applyStimulus(5'b01100, 5'b11111, 1'b1);
        checkOutput("lock.src3", 64'(out_src), 64'(5'b00100));
        applyStimulus(5'b01100, 5'b11111, 1'b1);
        checkOutput("lock.after", 64'(out_src), 64'(5'b01000));

        // Backpressure holds the output stage and blocks all requesters
        applyStimulus(5'b00011, 5'b11111, 1'b1);
        heldData = out_data;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(5'b00011, 5'b11111, 1'b0);
            checkOutput("bp.src", 64'(out_src), 64'(5'b00001));
            checkOutput("bp.data", 64'(out_data), 64'(heldData));
        end
        applyStimulus(5'b00011, 5'b11111, 1'b1);
        checkOutput("bp.resume", 64'(out_src), 64'(5'b00010));

        // Locked requester 2 goes quiet; others must not sneak in
        applyStimulus(5'b00100, 5'b00000, 1'b1);
        applyStimulus(5'b11011, 5'b11111, 1'b1);
        checkOutput("drop.vld", 64'(out_vld), 64'd0);
        applyStimulus(5'b11011, 5'b11111, 1'b1);
        checkOutput("drop.vld2", 64'(out_vld), 64'd0);
        applyStimulus(5'b11111, 5'b11111, 1'b1);
        checkOutput("drop.resume", 64'(out_src), 64'(5'b00100));

        // Asynchronous reset in the middle of a locked packet
        applyStimulus(5'b00010, 5'b00000, 1'b1);
        req_vld = 5'b00011;
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkAll("asyncrst");
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(5'b00011, 5'b11111, 1'b1);
        checkOutput("rst.prio", 64'(out_src), 64'(5'b00001));

        // Randomized traffic: beats held until accepted, random backpressure
        for (int i = 0; i < CNT; i++) begin
            pend[i]  = 1'b0;
            pLast[i] = 1'b1;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < CNT; i++) begin
                if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
                    pend[i]  = 1'b1;
                    pLast[i] = ($urandom_range(2, 0) != 0);
                end
                rVld[i]  = pend[i];
                rLast[i] = pLast[i];
            end
            applyStimulus(rVld, rLast, $urandom_range(3, 0) != 0);
            if (lastGrant >= 0) pend[lastGrant] = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Round-robin arbiter with packet locking that shares one registered output channel among CNT valid/ready requesters. Each cycle it picks one requester (rotating priority), routes that requester's data through a one-hot mux, and registers it into a single output stage. Once a multi-beat packet wins, the grant stays on that requester until its `last` beat is accepted. It sits in front of any shared register-write or bus port that several masters drive.

## Interface
- `WIDTH`, 32, data width per requester
- `CNT`, 5, number of requesters (≥2)

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_vld`  in  CNT  per-requester valid
- `req_last`  in  CNT  per-requester last-beat flag; 1 for single-beat transfers
- `req_data`  in  WIDTH*CNT  requester i occupies bits [WIDTH*i +: WIDTH]
- `req_rdy`  out  CNT  per-requester ready; one-hot or zero
- `out_vld`  out  1  output valid (registered)
- `out_data`  out  WIDTH  output data (registered)
- `out_last`  out  1  output last flag (registered)
- `out_src`  out  CNT  one-hot source of the current output beat (registered)
- `out_rdy`  in  1  downstream ready

## Operation
- `load = !out_vld | out_rdy`. The output register accepts a beat only when `load` is high.
- Round-robin pointer `ptr` (one-hot, CNT bits): last requester that completed a packet. Reset value is bit CNT-1, so requester 0 has first priority.
- Pick, in IDLE:
  - `hi = req_vld & ~(2*ptr - 1)`, i.e. requesters strictly above `ptr`.
  - If `hi != 0`, grant the lowest set bit of `hi`; otherwise grant the lowest set bit of `req_vld`.
  - Lowest-set-bit isolation is `x & ~(x-1)`.
- FSM with two states:
  - IDLE: `grant = pick`. On an accepted beat (`load & |grant`):
    - with `req_last` of the winner = 0: `lock <= grant`, go to LOCK.
    - with `req_last` = 1: `ptr <= grant`, stay in IDLE.
  - LOCK: `grant = lock & req_vld`. Other requesters are ignored even if valid. On an accepted beat with the winner's `req_last` = 1: `ptr <= lock`, go to IDLE. A locked requester that drops valid stalls the channel, with no timeout.
- `req_rdy = grant & {CNT{load}}`. This is combinational from `req_vld`, state and `out_rdy`.
- On accept:
  - `out_data <= onehot-mux(req_data, grant)`
  - `out_last <= req_last[winner]`
  - `out_src <= grant`
  - `out_vld <= 1`
- If `load` is high and `grant == 0`: `out_vld <= 0`; data, last and src hold their values.
- Pointer wrap: when `ptr` = bit CNT-1, `hi` = 0 and the pick falls to the full `req_vld`, so selection wraps to index 0.
- Simultaneous events: the downstream pop and a new accept in the same cycle are legal, giving full throughput of one beat per cycle.

## Timing
- Reset values:
  - `out_vld`=0, `out_data`=0, `out_last`=0, `out_src`=0
  - `req_rdy`=0 (while `req_vld`=0)
  - state=IDLE, `lock`=0, `ptr`=1<<(CNT-1)
- Latency: a beat accepted in cycle n appears on `out_*` in cycle n+1.
- While `out_vld & !out_rdy`, all `out_*` hold stable and `req_rdy` = 0.
- Reset asserted mid-packet: the lock is dropped and the partial packet is abandoned. The requester must restart its packet after reset.
- Requesters must hold `req_vld`/`req_data`/`req_last` stable until `req_rdy`. The block does not check this.

## Structure
- Shared package/header: no typedefs are required. The `lsb_isolate` function (`x & ~(x-1)`) belongs in the common function include, because the same idiom is used by other muxes.
- Sub-module `rr_pick`: combinational masked-priority pick (`req_vld`, `ptr` → one-hot `pick`). Data selection instantiates the existing `one_hot_mux` with ONE_HOT_CHECK=0.
- All other logic (FSM, `ptr`, output register) lives in `rr_arb_mux`; expected size 150–250 lines.

## Test plan
- Reset, then `req_vld`=5'b10110 held with all `last`=1 and `out_rdy`=1 → grant order 1,2,4,1,2,4 on `out_src`, one beat per cycle, with `out_vld` first high in the cycle after the first accept.
- Wrap: `ptr` at requester 4, `req_vld`=5'b10001 → requester 0 is granted next, then 4.
- Lock: requester 2 sends 3 beats (`last` on the third) while requester 3 is valid throughout → `out_src` = 2,2,2,3 and `req_rdy[3]`=0 during the lock.
- Backpressure: `out_rdy`=0 for 4 cycles with `out_vld`=1 → `out_data`/`out_src` stable and `req_rdy`=0; `out_rdy`=1 → the next beat loads in the same cycle.
- Locked requester drops valid for 2 cycles mid-packet → `out_vld` goes 0, no other requester is granted, and the packet resumes from the same source.
- Assert `rst` during LOCK → all outputs reset asynchronously; after release, requester 0 has first priority even if the previously locked requester is valid.
